// File: rtl/regblock_pkg.sv
// regblock_pkg: source-select encodings and stack pointer width helper
package regblock_pkg;
  localparam logic [1:0] SRC_MEM = 2'b00;
  localparam logic [1:0] SRC_ALU = 2'b01;
  localparam logic [1:0] SRC_XFER = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;
  localparam logic [1:0] SH_SRC_MEM = 2'b00;
  localparam logic [1:0] SH_SRC_IMM = 2'b01;
  localparam logic [1:0] SH_SRC_XFER = 2'b10;
  localparam logic [1:0] SH_SRC_ALU = 2'b11;
  localparam logic RA_SRC_MEM = 1'b0;
  localparam logic RA_SRC_LINK = 1'b1;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ra_stack.sv
// ra_stack: return-address stack with sticky errors (REGBLOCK_RA_WRAP_EN: push when full overwrites oldest)
module ra_stack
  import regblock_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef REGBLOCK_RA_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, top_idx;
  logic do_repl, do_push, do_pop, wr_push, grow, ovf_evt, unf_evt;
  assign top_idx = ptr - PW'(1);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign top = empty ? '0 : mem[top_idx];
  assign do_repl = push & pop & ~empty;
  assign do_push = push & (~pop | empty);
  assign do_pop = pop & ~push & ~empty;
  assign grow = do_push & ~full;
  assign wr_push = do_push & (~full | WRAP);
  assign ovf_evt = do_push & full;
  assign unf_evt = pop & ~push & empty;
  always_ff @(posedge clock)
    if (!reset_n) begin
      ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_push) mem[ptr] <= din;
      if (do_repl) mem[top_idx] <= din;
      ptr <= wr_push ? ptr + PW'(1) : do_pop ? top_idx : ptr;
      count <= count + CW'(grow) - CW'(do_pop);
      overflow <= (overflow & ~err_clear) | ovf_evt;
      underflow <= (underflow & ~err_clear) | unf_evt;
    end
endmodule

// File: rtl/register_component.sv
// register_component: loadable WIDTH-bit register with synchronous active-low reset
module register_component #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock)
    if (!reset_n) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/reg_block_stacked.sv
// reg_block_stacked: mary/shelley/comp datapath registers plus return-address stack (REGBLOCK_RA_WRAP_EN: wrap when full)
module reg_block_stacked
  import regblock_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RA_DEPTH = 8,
  parameter int PC_STEP = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [WIDTH-1:0]                memval,
  input  logic [WIDTH-1:0]                aluout,
  input  logic [WIDTH-1:0]                immediate,
  input  logic [WIDTH-1:0]                pc,
  input  logic                            mary_write,
  input  logic                            shelley_write,
  input  logic                            comp_write,
  input  logic [1:0]                      mary_src,
  input  logic [1:0]                      shelley_src,
  input  logic                            ra_src,
  input  logic                            ra_push,
  input  logic                            ra_pop,
  input  logic                            err_clear,
  output logic [WIDTH-1:0]                mary_out,
  output logic [WIDTH-1:0]                shelley_out,
  output logic [WIDTH-1:0]                comp_out,
  output logic [WIDTH-1:0]                ra_out,
  output logic [$clog2(RA_DEPTH+1)-1:0]   ra_count,
  output logic                            ra_full,
  output logic                            ra_empty,
  output logic                            ra_overflow,
  output logic                            ra_underflow
);
  logic [WIDTH-1:0] mary_d, shelley_d, ra_in;
  always_comb begin
    mary_d = mary_src == SRC_MEM ? memval : mary_src == SRC_ALU ? aluout :
             mary_src == SRC_XFER ? shelley_out : immediate;
    shelley_d = shelley_src == SH_SRC_MEM ? memval : shelley_src == SH_SRC_IMM ? immediate :
                shelley_src == SH_SRC_XFER ? mary_out : aluout;
    ra_in = ra_src == RA_SRC_LINK ? pc + WIDTH'(PC_STEP) : memval;
  end
  register_component #(.WIDTH(WIDTH)) u_mary (
    .clock(clock), .reset_n(reset_n), .load(mary_write), .d(mary_d), .q(mary_out)
  );
  register_component #(.WIDTH(WIDTH)) u_shelley (
    .clock(clock), .reset_n(reset_n), .load(shelley_write), .d(shelley_d), .q(shelley_out)
  );
  register_component #(.WIDTH(WIDTH)) u_comp (
    .clock(clock), .reset_n(reset_n), .load(comp_write), .d(aluout), .q(comp_out)
  );
  ra_stack #(.WIDTH(WIDTH), .DEPTH(RA_DEPTH)) u_ra (
    .clock(clock), .reset_n(reset_n), .push(ra_push), .pop(ra_pop), .err_clear(err_clear),
    .din(ra_in), .top(ra_out), .count(ra_count), .full(ra_full), .empty(ra_empty),
    .overflow(ra_overflow), .underflow(ra_underflow)
  );
endmodule

// File: tb/tb_reg_block_stacked.sv
// tb_reg_block_stacked: randomized and directed checks of reg_block_stacked against a queue-based model
module tb_reg_block_stacked;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [15:0] memval, aluout, immediate, pc;
  logic mary_write, shelley_write, comp_write, ra_src, ra_push, ra_pop, err_clear;
  logic [1:0] mary_src, shelley_src;
  logic [15:0] mary_out, shelley_out, comp_out, ra_out;
  logic [3:0] ra_count;
  logic ra_full, ra_empty, ra_overflow, ra_underflow;
  int n_checks = 0, n_fail = 0;
  logic [15:0] m_mary, m_shelley, m_comp;
  logic [15:0] stk[$];
  logic m_ovf, m_unf;
  reg_block_stacked dut (
    .clock(clock), .reset_n(reset_n), .memval(memval), .aluout(aluout), .immediate(immediate),
    .pc(pc), .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
    .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src), .ra_push(ra_push),
    .ra_pop(ra_pop), .err_clear(err_clear), .mary_out(mary_out), .shelley_out(shelley_out),
    .comp_out(comp_out), .ra_out(ra_out), .ra_count(ra_count), .ra_full(ra_full),
    .ra_empty(ra_empty), .ra_overflow(ra_overflow), .ra_underflow(ra_underflow)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] m_top();
    return stk.size() > 0 ? stk[stk.size()-1] : 16'h0;
  endfunction
  task automatic idle();
    {mary_write, shelley_write, comp_write, ra_push, ra_pop, err_clear, ra_src} = '0;
    {mary_src, shelley_src} = '0;
  endtask
  task automatic step();
    logic [15:0] md, sd, rin;
    @(posedge clock);
    if (!reset_n) begin
      m_mary = 0; m_shelley = 0; m_comp = 0; m_ovf = 0; m_unf = 0;
      stk.delete();
    end else begin
      case (mary_src)
        2'd0: md = memval;
        2'd1: md = aluout;
        2'd2: md = m_shelley;
        default: md = immediate;
      endcase
      case (shelley_src)
        2'd0: sd = memval;
        2'd1: sd = immediate;
        2'd2: sd = m_mary;
        default: sd = aluout;
      endcase
      if (mary_write) m_mary = md;
      if (shelley_write) m_shelley = sd;
      if (comp_write) m_comp = aluout;
      rin = ra_src ? pc + 16'd2 : memval;
      if (err_clear) begin m_ovf = 0; m_unf = 0; end
      if (ra_push && ra_pop && stk.size() > 0) stk[stk.size()-1] = rin;
      else if (ra_push) begin
        if (stk.size() < 8) stk.push_back(rin);
        else begin
          m_ovf = 1;
`ifdef REGBLOCK_RA_WRAP_EN
          void'(stk.pop_front());
          stk.push_back(rin);
`endif
        end
      end else if (ra_pop) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_unf = 1;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    reset_n = 1;
  endtask
  task automatic test_reset();
    memval = 16'hFFFF; aluout = 16'h1111; immediate = 16'h2222; pc = 16'h3333;
    {mary_write, shelley_write, comp_write, ra_push, ra_pop, err_clear, ra_src} = '1;
    mary_src = 2'b11; shelley_src = 2'b11;
    reset_n = 0;
    step();
    n_checks++;
    if ({mary_out, shelley_out, comp_out, ra_out, ra_count, ra_overflow, ra_underflow, ra_full} !== '0 || ra_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: mary=%h shelley=%h comp=%h ra=%h cnt=%0d empty=%b ovf=%b unf=%b, required all 0 empty=1",
               mary_out, shelley_out, comp_out, ra_out, ra_count, ra_empty, ra_overflow, ra_underflow);
    end
    reset_n = 1; idle();
    mary_write = 1; mary_src = 2'b11; immediate = 16'h1234;
    step();
    n_checks++;
    if (mary_out !== 16'h1234) begin n_fail++; $display("FAIL imm_write: mary=%h required 1234", mary_out); end
  endtask
  task automatic test_swap();
    idle();
    mary_write = 1; mary_src = 2'b11; immediate = 16'h00AA;
    shelley_write = 1; shelley_src = 2'b01; memval = 16'h0055;
    step();
    immediate = 16'h0055;
    step();
    shelley_src = 2'b01;
    mary_write = 0; immediate = 16'h0055;
    step();
    mary_write = 1; mary_src = 2'b11; immediate = 16'h00AA; shelley_write = 0;
    step();
    shelley_write = 1; shelley_src = 2'b01; immediate = 16'h0055; mary_write = 0;
    step();
    mary_write = 1; shelley_write = 1; mary_src = 2'b10; shelley_src = 2'b10;
    step();
    n_checks++;
    if (mary_out !== 16'h0055 || shelley_out !== 16'h00AA) begin
      n_fail++; $display("FAIL swap: mary=%h shelley=%h required 0055 00aa", mary_out, shelley_out);
    end
    idle(); comp_write = 1; aluout = 16'hBEEF;
    step();
    n_checks++;
    if (comp_out !== 16'hBEEF) begin n_fail++; $display("FAIL comp: comp=%h required beef", comp_out); end
  endtask
  task automatic test_link_push();
    logic [15:0] exp_push[3] = '{16'h0102, 16'h0104, 16'h0106};
    do_reset();
    ra_src = 1; ra_push = 1; pc = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ra_out !== exp_push[i]) begin n_fail++; $display("FAIL link_push%0d: ra_out=%h required %h", i, ra_out, exp_push[i]); end
      pc = pc + 16'd2;
    end
    idle(); ra_pop = 1;
    for (int i = 2; i >= 0; i--) begin
      n_checks++;
      if (ra_out !== exp_push[i]) begin n_fail++; $display("FAIL link_pop%0d: ra_out=%h required %h", i, ra_out, exp_push[i]); end
      step();
    end
    idle();
    n_checks++;
    if (ra_empty !== 1'b1 || ra_out !== 16'h0) begin n_fail++; $display("FAIL link_empty: empty=%b ra_out=%h required 1 0000", ra_empty, ra_out); end
    ra_src = 1; ra_push = 1; pc = 16'hFFFF;
    step();
    n_checks++;
    if (ra_out !== 16'h0001) begin n_fail++; $display("FAIL link_wrap: ra_out=%h required 0001", ra_out); end
  endtask
  task automatic test_underflow();
    do_reset();
    ra_pop = 1;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ra_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_hold%0d: unf=%b required 1", i, ra_underflow); end
      step();
    end
    err_clear = 1;
    step();
    n_checks++;
    if (ra_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: unf=%b required 0", ra_underflow); end
    ra_pop = 1;
    step();
    idle();
    n_checks++;
    if (ra_underflow !== 1'b1 || ra_count !== 4'd0) begin n_fail++; $display("FAIL unf_clear_pop: unf=%b cnt=%0d required 1 0", ra_underflow, ra_count); end
    ra_push = 1; ra_pop = 1; err_clear = 1; memval = 16'h4242;
    step();
    idle();
    n_checks++;
    if (ra_underflow !== 1'b0 || ra_count !== 4'd1 || ra_out !== 16'h4242) begin
      n_fail++; $display("FAIL pushpop_empty: unf=%b cnt=%0d ra=%h required 0 1 4242", ra_underflow, ra_count, ra_out);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    ra_push = 1;
    for (int i = 1; i <= 9; i++) begin
      memval = 16'(i);
      step();
    end
    idle();
    n_checks++;
`ifdef REGBLOCK_RA_WRAP_EN
    if (ra_count !== 4'd8 || ra_out !== 16'd9 || ra_overflow !== 1'b1 || ra_full !== 1'b1) begin
      n_fail++; $display("FAIL overflow_wrap: cnt=%0d ra=%0d ovf=%b full=%b required 8 9 1 1", ra_count, ra_out, ra_overflow, ra_full);
    end
    ra_pop = 1;
    for (int v = 9; v >= 2; v--) begin
      n_checks++;
      if (ra_out !== 16'(v)) begin n_fail++; $display("FAIL wrap_pop: ra=%0d required %0d", ra_out, v); end
      step();
    end
    idle();
`else
    if (ra_count !== 4'd8 || ra_out !== 16'd8 || ra_overflow !== 1'b1 || ra_full !== 1'b1) begin
      n_fail++; $display("FAIL overflow: cnt=%0d ra=%0d ovf=%b full=%b required 8 8 1 1", ra_count, ra_out, ra_overflow, ra_full);
    end
`endif
    n_checks++;
    if (ra_out !== m_top() || ra_count !== 4'(stk.size())) begin n_fail++; $display("FAIL overflow_model: ra=%h cnt=%0d required %h %0d", ra_out, ra_count, m_top(), stk.size()); end
  endtask
  task automatic test_replace();
    do_reset();
    ra_push = 1;
    for (int i = 0; i < 5; i++) begin memval = 16'h0A00 + 16'(i); step(); end
    ra_pop = 1; memval = 16'hCAFE;
    step();
    idle();
    n_checks++;
    if (ra_count !== 4'd5 || ra_out !== 16'hCAFE || ra_overflow !== 1'b0) begin
      n_fail++; $display("FAIL replace: cnt=%0d ra=%h ovf=%b required 5 cafe 0", ra_count, ra_out, ra_overflow);
    end
    ra_pop = 1;
    step();
    idle();
    n_checks++;
    if (ra_out !== 16'h0A03) begin n_fail++; $display("FAIL replace_pop: ra=%h required 0a03", ra_out); end
    ra_push = 1; reset_n = 0;
    step();
    reset_n = 1; idle();
    n_checks++;
    if (ra_count !== 4'd0 || ra_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset: cnt=%0d empty=%b required 0 1", ra_count, ra_empty); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset_n = $urandom_range(0, 59) != 0;
      memval = 16'($urandom); aluout = 16'($urandom); immediate = 16'($urandom);
      pc = $urandom_range(0, 7) == 0 ? 16'hFFFE : 16'($urandom);
      mary_write = 1'($urandom); shelley_write = 1'($urandom); comp_write = 1'($urandom);
      mary_src = 2'($urandom); shelley_src = 2'($urandom); ra_src = 1'($urandom);
      ra_push = $urandom_range(0, 9) < (c % 80 < 40 ? 6 : 3);
      ra_pop = $urandom_range(0, 9) < (c % 80 < 40 ? 3 : 6);
      err_clear = $urandom_range(0, 15) == 0;
      step();
      n_checks++;
      if (mary_out !== m_mary || shelley_out !== m_shelley || comp_out !== m_comp || ra_out !== m_top() ||
          ra_count !== 4'(stk.size()) || ra_full !== (stk.size() == 8) || ra_empty !== (stk.size() == 0) ||
          ra_overflow !== m_ovf || ra_underflow !== m_unf) begin
        n_fail++;
        $display("FAIL random@%0d: got m=%h s=%h c=%h ra=%h cnt=%0d f=%b e=%b o=%b u=%b required m=%h s=%h c=%h ra=%h cnt=%0d o=%b u=%b",
                 c, mary_out, shelley_out, comp_out, ra_out, ra_count, ra_full, ra_empty, ra_overflow, ra_underflow,
                 m_mary, m_shelley, m_comp, m_top(), stk.size(), m_ovf, m_unf);
      end
    end
    idle(); reset_n = 1;
  endtask
  initial begin
    idle();
    {memval, aluout, immediate, pc} = '0;
    test_reset();
    test_swap();
    test_link_push();
    test_underflow();
    test_overflow();
    test_replace();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
